// File: rtl/subneg_control.sv
// subneg_control
// ----------------
// Sequencer for a SUBNEG one-instruction processor. Each instruction is
// three words (A, B, C) in a shared synchronous-read memory. The sequencer
// fetches A, B and C, reads mem[A] and mem[B], and hands them to an
// external combinational subtractor. It then writes the difference back to
// mem[B] and branches to C when the result is negative, otherwise it
// advances to PC+3. An instruction whose next PC equals its own PC halts
// the machine after its write-back.
//
// Ports
//   clock        : rising-edge clock
//   reset_n      : asynchronous active-low reset
//   start        : begin execution at START_ADDR (only honoured in IDLE)
//   mem_addr     : memory address (read data returns one cycle later)
//   mem_rdata    : memory read data
//   mem_wdata    : memory write data
//   mem_we       : memory write enable (single-cycle pulse in WB)
//   sub_in1      : subtrahend mem[A] to the subtractor
//   sub_in2      : minuend mem[B] to the subtractor
//   sub_out      : subtractor result in2 - in1
//   sub_neg      : sign bit of sub_out
//   pc           : current program counter
//   busy         : executing (between accepted start and halt)
//   halted       : sticky halt flag, cleared only by reset
//   instr_count  : completed instructions, wraps
module subneg_control #(
  parameter int WIDTH      = 8,
  parameter int START_ADDR = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     mem_addr,
  input  logic [WIDTH-1:0]     mem_rdata,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 mem_we,
  output logic [WIDTH-1:0]     sub_in1,
  output logic [WIDTH-1:0]     sub_in2,
  input  logic [WIDTH-1:0]     sub_out,
  input  logic                 sub_neg,
  output logic [WIDTH-1:0]     pc,
  output logic                 busy,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    IDLE, FA, FB, FC, RA, RB, EX, WB, HALT
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     pc_q, pc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_ptr_q, a_ptr_d;
  logic [WIDTH-1:0]     b_ptr_q, b_ptr_d;
  logic [WIDTH-1:0]     c_ptr_q, c_ptr_d;
  logic [WIDTH-1:0]     op_a_q, op_a_d;
  logic [WIDTH-1:0]     op_b_q, op_b_d;
  // Last address / write data driven; presented whenever the current state
  // does not drive a new value, so both hold in IDLE, EX and HALT.
  logic [WIDTH-1:0]     addr_q, addr_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;
  logic [WIDTH-1:0]     next_pc;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    a_ptr_d   = a_ptr_q;
    b_ptr_d   = b_ptr_q;
    c_ptr_d   = c_ptr_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_we    = 1'b0;
    // Taken branch goes to C; address arithmetic wraps at WIDTH bits.
    next_pc   = sub_neg ? c_ptr_q : pc_q + WIDTH'(3);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FA;
          pc_d    = WIDTH'(START_ADDR);
          cnt_d   = '0;
        end
      end
      FA: begin
        mem_addr = pc_q;
        state_d  = FB;
      end
      FB: begin
        mem_addr = pc_q + WIDTH'(1);
        a_ptr_d  = mem_rdata;
        state_d  = FC;
      end
      FC: begin
        mem_addr = pc_q + WIDTH'(2);
        b_ptr_d  = mem_rdata;
        state_d  = RA;
      end
      RA: begin
        mem_addr = a_ptr_q;
        c_ptr_d  = mem_rdata;
        state_d  = RB;
      end
      RB: begin
        mem_addr = b_ptr_q;
        op_a_d   = mem_rdata;
        state_d  = EX;
      end
      EX: begin
        op_b_d  = mem_rdata;
        state_d = WB;
      end
      WB: begin
        mem_addr  = b_ptr_q;
        mem_wdata = sub_out;
        mem_we    = 1'b1;
        pc_d      = next_pc;
        cnt_d     = cnt_q + CNT_WIDTH'(1);
        // A self-loop can never make progress, so it is the halt idiom.
        state_d   = (next_pc == pc_q) ? HALT : FA;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    addr_d  = mem_addr;
    wdata_d = mem_wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      a_ptr_q <= '0;
      b_ptr_q <= '0;
      c_ptr_q <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      a_ptr_q <= a_ptr_d;
      b_ptr_q <= b_ptr_d;
      c_ptr_q <= c_ptr_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign sub_in1     = op_a_q;
  assign sub_in2     = op_b_q;
  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign busy        = (state_q != IDLE) && (state_q != HALT);
  assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_subneg_control.sv
// Bench for subneg_control: two instances (START_ADDR 0 and 253), each with
// its own synchronous memory and subtractor. A SUBNEG reference model
// predicts every write-back, which is queued and checked as the DUT writes.
module tb_subneg_control;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;

  logic [7:0]  addr0, rdata0, wdata0, in1_0, in2_0, out0, pc0;
  logic        we0, neg0, busy0, halted0;
  logic [15:0] cnt0;
  logic [7:0]  addr1, rdata1, wdata1, in1_1, in2_1, out1, pc1;
  logic        we1, neg1, busy1, halted1;
  logic [15:0] cnt1;

  assign out0 = in2_0 - in1_0;
  assign neg0 = out0[7];
  assign out1 = in2_1 - in1_1;
  assign neg1 = out1[7];

  subneg_control #(.WIDTH(8), .START_ADDR(0), .CNT_WIDTH(16)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start0),
    .mem_addr(addr0), .mem_rdata(rdata0), .mem_wdata(wdata0), .mem_we(we0),
    .sub_in1(in1_0), .sub_in2(in2_0), .sub_out(out0), .sub_neg(neg0),
    .pc(pc0), .busy(busy0), .halted(halted0), .instr_count(cnt0)
  );

  subneg_control #(.WIDTH(8), .START_ADDR(253), .CNT_WIDTH(16)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1),
    .mem_addr(addr1), .mem_rdata(rdata1), .mem_wdata(wdata1), .mem_we(we1),
    .sub_in1(in1_1), .sub_in2(in2_1), .sub_out(out1), .sub_neg(neg1),
    .pc(pc1), .busy(busy1), .halted(halted1), .instr_count(cnt1)
  );

  // Memories with a bench load port that takes priority over the DUT.
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic       ld0 = 1'b0, ld1 = 1'b0;
  logic [7:0] ld_addr = 8'd0, ld_data = 8'd0;

  always @(posedge clock) begin
    if (ld0) mem0[ld_addr] <= ld_data;
    else if (we0) mem0[addr0] <= wdata0;
    rdata0 <= mem0[addr0];
  end

  always @(posedge clock) begin
    if (ld1) mem1[ld_addr] <= ld_data;
    else if (we1) mem1[addr1] <= wdata1;
    rdata1 <= mem1[addr1];
  end

  // Monitor selection
  bit          mon_sel = 1'b0;
  logic        mon_we, mon_busy, mon_halted, mon_neg;
  logic [7:0]  mon_addr, mon_wdata, mon_pc;
  logic [15:0] mon_cnt;
  assign mon_we     = mon_sel ? we1     : we0;
  assign mon_busy   = mon_sel ? busy1   : busy0;
  assign mon_halted = mon_sel ? halted1 : halted0;
  assign mon_neg    = mon_sel ? neg1    : neg0;
  assign mon_addr   = mon_sel ? addr1   : addr0;
  assign mon_wdata  = mon_sel ? wdata1  : wdata0;
  assign mon_pc     = mon_sel ? pc1     : pc0;
  assign mon_cnt    = mon_sel ? cnt1    : cnt0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] npc;
  } wb_t;

  wb_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  logic [7:0] model [256];
  logic [7:0] pred  [256];
  logic       first_neg;

  // Scoreboard: each write pops the predicted write-back; PC is checked on
  // the following cycle.
  bit         pc_pending = 1'b0;
  logic [7:0] pc_exp = 8'd0;
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      pc_pending = 1'b0;
    end else begin
      if (pc_pending) begin
        checks++;
        if (mon_pc !== pc_exp) begin
          errors++;
          $display("FAIL sb_pc: got %0d expected %0d", mon_pc, pc_exp);
        end
        pc_pending = 1'b0;
      end
      if (mon_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_write: unexpected write addr=%0d data=%02h", mon_addr, mon_wdata);
        end else begin
          wb_t e;
          e = exp_q.pop_front();
          if (mon_addr !== e.addr || mon_wdata !== e.data) begin
            errors++;
            $display("FAIL sb_write: got addr=%0d data=%02h expected addr=%0d data=%02h",
                     mon_addr, mon_wdata, e.addr, e.data);
          end else begin
            $display("write mem[%0d]=%02h ok", mon_addr, mon_wdata);
          end
          pc_exp     = e.npc;
          pc_pending = 1'b1;
        end
      end
    end
  end

  task automatic load(input bit sel, input logic [7:0] a, input logic [7:0] d);
    ld_addr = a;
    ld_data = d;
    if (sel) ld1 = 1'b1; else ld0 = 1'b1;
    model[a] = d;
    @(posedge clock);
    #1;
    ld0 = 1'b0;
    ld1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Reference SUBNEG model: runs on a copy of the loaded memory image.
  task automatic predict(input logic [7:0] spc, output int n,
                         output logic [7:0] fpc, output logic [7:0] last_b);
    logic [7:0] p, a, b, c, r, np, i1, i2;
    wb_t e;
    pred   = model;
    p      = spc;
    n      = 0;
    last_b = 8'd0;
    for (int k = 0; k < 50; k++) begin
      i1 = p + 8'd1;
      i2 = p + 8'd2;
      a  = pred[p];
      b  = pred[i1];
      c  = pred[i2];
      r  = pred[b] - pred[a];
      pred[b] = r;
      np = r[7] ? c : p + 8'd3;
      e.addr = b; e.data = r; e.npc = np;
      exp_q.push_back(e);
      n++;
      last_b = b;
      if (np == p) break;
      p = np;
    end
    fpc = p;
  endtask

  task automatic execute(input bit sel, input logic [7:0] spc, input bit poke,
                         input string name, output int n);
    logic [7:0] fpc, last_b, a1, a2;
    logic [7:0] tr [3];
    int  bcnt;
    bit  done, first_seen;
    mon_sel = sel;
    predict(spc, n, fpc, last_b);
    @(negedge clock);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clock);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    checks++;
    if (mon_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s start_latency: busy got %b expected 1", name, mon_busy);
    end
    bcnt = 0; done = 1'b0; first_seen = 1'b0; first_neg = 1'bx;
    for (int i = 0; i < 3; i++) tr[i] = 8'hxx;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clock);
      if (poke && cyc == 10) begin
        if (sel) start1 = 1'b0; else start0 = 1'b0;
      end
      if (mon_halted === 1'b1) begin
        done = 1'b1;
        break;
      end
      if (cyc < 3) tr[cyc] = mon_addr;
      if (mon_busy === 1'b1) bcnt++;
      if (mon_we === 1'b1 && !first_seen) begin
        first_seen = 1'b1;
        first_neg  = mon_neg;
      end
      if (poke && cyc == 9) begin
        if (sel) start1 = 1'b1; else start0 = 1'b1;
      end
    end
    start0 = 1'b0;
    start1 = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s halt_timeout: halted never rose", name);
    end
    checks++;
    if (bcnt != 7 * n) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, bcnt, 7 * n);
    end
    checks++;
    if (mon_cnt !== 16'(n)) begin
      errors++;
      $display("FAIL %s instr_count: got %0d expected %0d", name, mon_cnt, n);
    end
    checks++;
    if (mon_pc !== fpc) begin
      errors++;
      $display("FAIL %s final_pc: got %0d expected %0d", name, mon_pc, fpc);
    end
    a1 = spc + 8'd1;
    a2 = spc + 8'd2;
    checks++;
    if (tr[0] !== spc || tr[1] !== a1 || tr[2] !== a2) begin
      errors++;
      $display("FAIL %s fetch_addrs: got %0d,%0d,%0d expected %0d,%0d,%0d",
               name, tr[0], tr[1], tr[2], spc, a1, a2);
    end
    @(negedge clock);
    checks++;
    if (mon_halted !== 1'b1 || mon_busy !== 1'b0 || mon_we !== 1'b0) begin
      errors++;
      $display("FAIL %s halt_sticky: halted=%b busy=%b we=%b expected 1,0,0",
               name, mon_halted, mon_busy, mon_we);
    end
    checks++;
    if (mon_addr !== last_b) begin
      errors++;
      $display("FAIL %s addr_hold: got %0d expected %0d", name, mon_addr, last_b);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s sb_leftover: got %0d pending expected 0", name, exp_q.size());
    end
    $display("%s: %0d instructions, %0d busy cycles, pc=%0d", name, n, bcnt, mon_pc);
    model = pred;
  endtask

  task automatic load_base(input logic [7:0] m6, input logic [7:0] m7);
    load(0, 0, 6); load(0, 1, 7); load(0, 2, 3);
    load(0, 3, 8); load(0, 4, 9); load(0, 5, 3);
    load(0, 6, m6); load(0, 7, m7); load(0, 8, 1); load(0, 9, 0);
  endtask

  task automatic check_mem0(input string name, input logic [7:0] a, input logic [7:0] d);
    checks++;
    if (mem0[a] !== d) begin
      errors++;
      $display("FAIL %s mem[%0d]: got %02h expected %02h", name, a, mem0[a], d);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (addr0 !== 8'd0 || wdata0 !== 8'd0 || we0 !== 1'b0 || in1_0 !== 8'd0 ||
        in2_0 !== 8'd0 || pc0 !== 8'd0 || busy0 !== 1'b0 || halted0 !== 1'b0 ||
        cnt0 !== 16'd0) begin
      errors++;
      $display("FAIL reset_values: addr=%0d wd=%0d we=%b in1=%0d in2=%0d pc=%0d busy=%b halt=%b cnt=%0d expected all 0",
               addr0, wdata0, we0, in1_0, in2_0, pc0, busy0, halted0, cnt0);
    end
    checks++;
    if (busy1 !== 1'b0 || halted1 !== 1'b0 || pc1 !== 8'd0) begin
      errors++;
      $display("FAIL reset_values_dut1: busy=%b halted=%b pc=%0d expected 0,0,0", busy1, halted1, pc1);
    end
    @(negedge clock);
    reset_n = 1'b1;
    $display("reset: outputs checked");
  endtask

  task automatic test_branch_taken();
    int n;
    do_reset();
    load_base(8'd5, 8'd2);
    execute(0, 8'd0, 1'b0, "branch_taken", n);
    check_mem0("branch_taken", 8'd7, 8'hFD);
    check_mem0("branch_taken", 8'd9, 8'hFF);
    checks++;
    if (cnt0 !== 16'd2 || pc0 !== 8'd3 || first_neg !== 1'b1) begin
      errors++;
      $display("FAIL branch_taken summary: cnt=%0d pc=%0d neg=%b expected 2,3,1", cnt0, pc0, first_neg);
    end
    // start must be ignored once halted
    @(negedge clock); start0 = 1'b1;
    @(negedge clock); start0 = 1'b0;
    @(negedge clock);
    checks++;
    if (halted0 !== 1'b1 || busy0 !== 1'b0 || pc0 !== 8'd3) begin
      errors++;
      $display("FAIL start_in_halt: halted=%b busy=%b pc=%0d expected 1,0,3", halted0, busy0, pc0);
    end
  endtask

  task automatic test_value(input string name, input logic [7:0] m6, input logic [7:0] m7,
                            input logic [7:0] r7, input logic neg);
    int n;
    do_reset();
    load_base(m6, m7);
    execute(0, 8'd0, 1'b0, name, n);
    check_mem0(name, 8'd7, r7);
    checks++;
    if (first_neg !== neg) begin
      errors++;
      $display("FAIL %s sub_neg: got %b expected %b", name, first_neg, neg);
    end
  endtask

  task automatic test_pc_wrap();
    int n;
    do_reset();
    load(1, 253, 250); load(1, 254, 251); load(1, 255, 0);
    load(1, 250, 1);   load(1, 251, 5);
    load(1, 0, 8);     load(1, 1, 9);     load(1, 2, 0);
    load(1, 8, 1);     load(1, 9, 0);
    execute(1, 8'd253, 1'b0, "pc_wrap", n);
    checks++;
    if (mem1[251] !== 8'd4 || mem1[9] !== 8'hFF || pc1 !== 8'd0 || n != 2) begin
      errors++;
      $display("FAIL pc_wrap result: mem251=%02h mem9=%02h pc=%0d n=%0d expected 04,FF,0,2",
               mem1[251], mem1[9], pc1, n);
    end
    mon_sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    load_base(8'd5, 8'd2);
    // Reset during RB
    @(negedge clock); start0 = 1'b1;
    @(posedge clock); #1; start0 = 1'b0;          // FA
    repeat (4) @(posedge clock);                   // RB
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (we0 !== 1'b0 || busy0 !== 1'b0 || addr0 !== 8'd0 || pc0 !== 8'd0 ||
        in1_0 !== 8'd0 || in2_0 !== 8'd0 || wdata0 !== 8'd0 || cnt0 !== 16'd0 ||
        halted0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_rb: we=%b busy=%b addr=%0d pc=%0d in1=%0d in2=%0d expected all 0",
               we0, busy0, addr0, pc0, in1_0, in2_0);
    end
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    // Reset during WB: write enable must drop immediately
    @(negedge clock); start0 = 1'b1;
    @(posedge clock); #1; start0 = 1'b0;          // FA
    repeat (6) @(posedge clock);                   // WB
    #1;
    checks++;
    if (we0 !== 1'b1) begin
      errors++;
      $display("FAIL wb_we: got %b expected 1", we0);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (we0 !== 1'b0 || busy0 !== 1'b0 || wdata0 !== 8'd0) begin
      errors++;
      $display("FAIL reset_in_wb: we=%b busy=%b wdata=%0d expected 0,0,0", we0, busy0, wdata0);
    end
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    check_mem0("reset_mid no_write", 8'd7, 8'd2);
    execute(0, 8'd0, 1'b0, "restart_after_reset", n);
    check_mem0("restart_after_reset", 8'd7, 8'hFD);
  endtask

  task automatic test_start_while_busy();
    int n;
    do_reset();
    load_base(8'd5, 8'd2);
    execute(0, 8'd0, 1'b1, "start_while_busy", n);
    check_mem0("start_while_busy", 8'd7, 8'hFD);
    check_mem0("start_while_busy", 8'd9, 8'hFF);
  endtask

  initial begin
    test_reset();
    test_branch_taken();
    test_value("no_branch", 8'd2, 8'd5, 8'd3, 1'b0);
    test_value("zero_result", 8'd4, 8'd4, 8'd0, 1'b0);
    test_value("overflow", 8'd1, 8'h80, 8'h7F, 1'b0);
    test_pc_wrap();
    test_reset_mid();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
